// File: rtl/synth_pkg.sv
// Shared constants, types and the note tuning table for the voice allocation path.
package synth_pkg;

   localparam real F_SAMPLE    = 48000.0;
   localparam int  NOTE_W      = 7;
   localparam int  VEL_W       = 7;
   localparam int  TUNING_W    = 32;
   localparam int  VOICE_IDX_W = 8;
   localparam int  COUNT_W     = 9;
   localparam int  NUM_NOTES   = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_ISSUE = 2'd2
   } alloc_state_t;

   typedef logic [NUM_NOTES-1:0][TUNING_W-1:0] tuning_table_t;

   // DDS phase increment: round(f_note * 2^32 / F_SAMPLE), equal temperament around A4 = 440 Hz.
   function automatic logic [TUNING_W-1:0] calc_tuning(input int n);
      real f_note;
      f_note = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
      return TUNING_W'($rtoi(f_note * 4294967296.0 / F_SAMPLE + 0.5));
   endfunction

   function automatic tuning_table_t build_tuning_table();
      tuning_table_t t;
      for (int n = 0; n < NUM_NOTES; n++) begin
         t[n] = calc_tuning(n);
      end
      return t;
   endfunction

   localparam tuning_table_t TUNING_TABLE = build_tuning_table();

endpackage

// File: rtl/voice_allocator_if.sv
// Event input and voice command output bundle between the MIDI decoder, allocator and voice_controller.
interface voice_allocator_if;
   import synth_pkg::*;

   logic                   i_note_valid;
   logic                   o_note_ready;
   logic                   i_note_on;
   logic [NOTE_W-1:0]      i_note_num;
   logic [VEL_W-1:0]       i_velocity;
   logic                   o_flag;
   logic                   o_note_status;
   logic [VOICE_IDX_W-1:0] o_voice_index;
   logic [TUNING_W-1:0]    o_tuning_code;
   logic [VEL_W-1:0]       o_velocity;
   logic [COUNT_W-1:0]     o_active_count;

   modport master (
      output i_note_valid, i_note_on, i_note_num, i_velocity,
      input  o_note_ready, o_flag, o_note_status, o_voice_index,
             o_tuning_code, o_velocity, o_active_count
   );

   modport slave (
      input  i_note_valid, i_note_on, i_note_num, i_velocity,
      output o_note_ready, o_flag, o_note_status, o_voice_index,
             o_tuning_code, o_velocity, o_active_count
   );
endinterface

// File: rtl/note_tuning_rom.sv
// Synchronous 128x32 note-to-phase-increment ROM, one-cycle read latency.
module note_tuning_rom
   import synth_pkg::*;
(
   input  logic                i_clk,
   input  logic                en,
   input  logic [NOTE_W-1:0]   addr,
   output logic [TUNING_W-1:0] data
);

   always_ff @(posedge i_clk) begin
      if (en) begin
         data <= TUNING_TABLE[addr];
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans the slot table one entry per cycle, then issues
// a single-cycle command (retrigger, else first free slot, else steal the oldest).
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 16,
   parameter int AGE_W      = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   voice_allocator_if.slave   bus
);

   localparam int               IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic [AGE_W-1:0] AGE_MAX  = '1;

   alloc_state_t        state;
   logic [IDX_W-1:0]    scan_idx;
   logic                lat_on;
   logic [NOTE_W-1:0]   lat_note;
   logic [VEL_W-1:0]    lat_vel;

   logic                slot_active [NUM_VOICES];
   logic [NOTE_W-1:0]   slot_note   [NUM_VOICES];
   logic [AGE_W-1:0]    slot_age    [NUM_VOICES];

   logic                match_hit, free_hit, old_hit;
   logic [IDX_W-1:0]    match_idx, free_idx, old_idx;
   logic [AGE_W-1:0]    old_age;
   logic                nxt_match_hit, nxt_free_hit, nxt_old_hit;
   logic [IDX_W-1:0]    nxt_match_idx, nxt_free_idx, nxt_old_idx;
   logic [AGE_W-1:0]    nxt_old_age;

   logic                cmd_valid, cmd_new;
   logic [IDX_W-1:0]    cmd_idx;
   logic                accept;
   logic [TUNING_W-1:0] rom_data;

   assign accept = (state == ST_IDLE) && bus.i_note_valid && bus.o_note_ready;

   note_tuning_rom u_rom (
      .i_clk (i_clk),
      .en    (accept),
      .addr  (bus.i_note_num),
      .data  (rom_data)
   );

   // Fold the slot under scan into the running match/free/oldest results and form the final decision.
   always_comb begin
      nxt_match_hit = match_hit;
      nxt_match_idx = match_idx;
      nxt_free_hit  = free_hit;
      nxt_free_idx  = free_idx;
      nxt_old_hit   = old_hit;
      nxt_old_idx   = old_idx;
      nxt_old_age   = old_age;
      if (slot_active[scan_idx]) begin
         if (!match_hit && (slot_note[scan_idx] == lat_note)) begin
            nxt_match_hit = 1'b1;
            nxt_match_idx = scan_idx;
         end
         if (!old_hit || (slot_age[scan_idx] > old_age)) begin
            nxt_old_hit = 1'b1;
            nxt_old_idx = scan_idx;
            nxt_old_age = slot_age[scan_idx];
         end
      end else if (!free_hit) begin
         nxt_free_hit = 1'b1;
         nxt_free_idx = scan_idx;
      end

      cmd_valid = 1'b0;
      cmd_new   = 1'b0;
      cmd_idx   = nxt_match_idx;
      if (lat_on) begin
         cmd_valid = 1'b1;
         if (!nxt_match_hit && nxt_free_hit) begin
            cmd_idx = nxt_free_idx;
            cmd_new = 1'b1;
         end else if (!nxt_match_hit) begin
            cmd_idx = nxt_old_idx;
         end
      end else if (nxt_match_hit) begin
         cmd_valid = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state              <= ST_IDLE;
         scan_idx           <= '0;
         bus.o_note_ready   <= 1'b0;
         bus.o_flag         <= 1'b0;
         bus.o_note_status  <= 1'b0;
         bus.o_voice_index  <= '0;
         bus.o_tuning_code  <= '0;
         bus.o_velocity     <= '0;
         bus.o_active_count <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            slot_active[i] <= 1'b0;
            slot_age[i]    <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               bus.o_flag <= 1'b0;
               if (accept) begin
                  lat_on           <= bus.i_note_on && (bus.i_velocity != '0);
                  lat_note         <= bus.i_note_num;
                  lat_vel          <= bus.i_velocity;
                  scan_idx         <= '0;
                  match_hit        <= 1'b0;
                  free_hit         <= 1'b0;
                  old_hit          <= 1'b0;
                  bus.o_note_ready <= 1'b0;
                  state            <= ST_SCAN;
               end else begin
                  bus.o_note_ready <= 1'b1;
               end
            end
            ST_SCAN: begin
               match_hit <= nxt_match_hit;
               match_idx <= nxt_match_idx;
               free_hit  <= nxt_free_hit;
               free_idx  <= nxt_free_idx;
               old_hit   <= nxt_old_hit;
               old_idx   <= nxt_old_idx;
               old_age   <= nxt_old_age;
               scan_idx  <= scan_idx + 1'b1;
               // The command is registered on the edge into ISSUE so the strobe is visible during ISSUE.
               if (scan_idx == LAST_IDX) begin
                  state <= ST_ISSUE;
                  if (cmd_valid) begin
                     bus.o_flag        <= 1'b1;
                     bus.o_note_status <= lat_on;
                     bus.o_voice_index <= VOICE_IDX_W'(cmd_idx);
                     bus.o_tuning_code <= rom_data;
                     bus.o_velocity    <= lat_on ? lat_vel : '0;
                     if (lat_on && cmd_new && (bus.o_active_count != COUNT_W'(NUM_VOICES))) begin
                        bus.o_active_count <= bus.o_active_count + 1'b1;
                     end else if (!lat_on && (bus.o_active_count != '0)) begin
                        bus.o_active_count <= bus.o_active_count - 1'b1;
                     end
                     for (int i = 0; i < NUM_VOICES; i++) begin
                        if (lat_on) begin
                           if (IDX_W'(i) == cmd_idx) begin
                              slot_active[i] <= 1'b1;
                              slot_note[i]   <= lat_note;
                              slot_age[i]    <= '0;
                           end else if (slot_active[i] && (slot_age[i] != AGE_MAX)) begin
                              slot_age[i] <= slot_age[i] + 1'b1;
                           end
                        end else if (IDX_W'(i) == cmd_idx) begin
                           slot_active[i] <= 1'b0;
                           slot_age[i]    <= '0;
                        end
                     end
                  end
               end
            end
            ST_ISSUE: begin
               bus.o_flag       <= 1'b0;
               bus.o_note_ready <= 1'b1;
               state            <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
